// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: packs a framed program image into big-endian words,
// writes instruction memory, and releases the CPU reset once the checksum verifies.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] word_count
);

    localparam logic [2:0] ST_WAIT_MAGIC = 3'd0;
    localparam logic [2:0] ST_LEN_HI     = 3'd1;
    localparam logic [2:0] ST_LEN_LO     = 3'd2;
    localparam logic [2:0] ST_DATA       = 3'd3;
    localparam logic [2:0] ST_CHECK      = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;
    localparam logic [2:0] ST_ERROR      = 3'd6;

    localparam logic [7:0]  MAGIC   = 8'hA5;
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [15:0] len_r;
    logic [23:0] word_r;
    logic [1:0]  byte_cnt_r;
    logic [7:0]  chk_r;
    logic [15:0] word_count_r;
    logic        rx_ready_r;
    logic        imem_we_r;
    logic [31:0] imem_addr_r;
    logic [31:0] imem_wdata_r;
    logic        cpu_reset_r;
    logic        load_done_r;
    logic        load_error_r;
    logic        accept_s;
    logic [15:0] len_s;
    logic        last_word_s;

    // Handshake and decode helpers for the byte currently on the bus
    always_comb begin
        accept_s    = rx_valid && rx_ready_r;
        len_s       = {len_r[15:8], rx_data};
        last_word_s = (16'(word_count_r + 16'd1) == len_r);
    end

    // Frame parser next-state logic; idle cycles hold the current state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_WAIT_MAGIC: begin
                if (accept_s && (rx_data == MAGIC)) next_state_s = ST_LEN_HI;
                else                                next_state_s = state_r;
            end
            ST_LEN_HI: begin
                if (accept_s) next_state_s = ST_LEN_LO;
                else          next_state_s = state_r;
            end
            ST_LEN_LO: begin
                if (!accept_s)                      next_state_s = state_r;
                else if ({1'b0, len_s} > MAX_LEN)   next_state_s = ST_ERROR;
                else if (len_s == 16'd0)            next_state_s = ST_CHECK;
                else                                next_state_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s && (byte_cnt_r == 2'd3) && last_word_s) next_state_s = ST_CHECK;
                else                                                 next_state_s = state_r;
            end
            ST_CHECK: begin
                if (!accept_s)              next_state_s = state_r;
                else if (rx_data == chk_r)  next_state_s = ST_DONE;
                else                        next_state_s = ST_ERROR;
            end
            ST_DONE: next_state_s = ST_DONE;
            ST_ERROR: begin
                if (accept_s && (rx_data == MAGIC)) next_state_s = ST_LEN_HI;
                else                                next_state_s = state_r;
            end
            default: next_state_s = ST_WAIT_MAGIC;
        endcase
    end

    // State, status flags and write-port datapath; status is decoded from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_WAIT_MAGIC;
            len_r        <= 16'd0;
            word_r       <= 24'd0;
            byte_cnt_r   <= 2'd0;
            chk_r        <= 8'd0;
            word_count_r <= 16'd0;
            rx_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= BASE_ADDR;
            imem_wdata_r <= 32'd0;
            cpu_reset_r  <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            rx_ready_r   <= (next_state_s != ST_DONE);
            load_done_r  <= (next_state_s == ST_DONE);
            cpu_reset_r  <= (next_state_s != ST_DONE);
            load_error_r <= (next_state_s == ST_ERROR);
            imem_we_r    <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    ST_LEN_HI: len_r[15:8] <= rx_data;
                    ST_LEN_LO: begin
                        len_r        <= len_s;
                        word_count_r <= 16'd0;
                        chk_r        <= 8'd0;
                        byte_cnt_r   <= 2'd0;
                    end
                    ST_DATA: begin
                        word_r     <= {word_r[15:0], rx_data};
                        chk_r      <= chk_update(chk_r, rx_data);
                        byte_cnt_r <= 2'(byte_cnt_r + 2'd1);
                        if (byte_cnt_r == 2'd3) begin
                            imem_we_r    <= 1'b1;
                            imem_addr_r  <= BASE_ADDR + {14'd0, word_count_r, 2'b00};
                            imem_wdata_r <= {word_r, rx_data};
                            word_count_r <= 16'(word_count_r + 16'd1);
                        end
                    end
                    ST_ERROR: begin
                        if (rx_data == MAGIC) begin
                            word_count_r <= 16'd0;
                            chk_r        <= 8'd0;
                            byte_cnt_r   <= 2'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_reset  = cpu_reset_r;
    assign load_done  = load_done_r;
    assign load_error = load_error_r;
    assign word_count = word_count_r;

endmodule
